ctl_sequencer: RTL and testbench

CTL_SEQUENCER -- requirements
Module: ctl_sequencer

---
 rtl/ctl_sequencer.sv | 163 ++++++++++++++++
 tb/tb_ctl_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctl_sequencer.sv
// Multi-cycle control sequencer: fetches an instruction word into an IR and steps through
// BOOT/FETCH/DECODE/EXEC/MEM/WB, producing datapath strobes and a retired-instruction count.
module ctl_sequencer #(
  parameter int unsigned RET_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [31:0]      ins,
  input  logic             zero,
  output logic             INT,
  output logic             pc_we,
  output logic             ir_we,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [2:0]       op,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Mem2Reg,
  output logic             isBranch,
  output logic             isJump,
  output logic             halt,
  output logic [RET_W-1:0] retired
);

  typedef enum logic [2:0] {
    StBoot, StFetch, StDecode, StExec, StMem, StWb, StHalt
  } state_t;

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b110;

  state_t           state_q, state_d;
  logic [31:0]      ir_q;
  logic [RET_W-1:0] retired_q;

  logic is_r, is_i, is_lw, is_sw, is_beq, is_jal, legal;
  logic [2:0] alu_op;
  logic       alu_src;

  // PC selection by zero happens in the datapath; isBranch is unconditional here.
  logic unused_in;
  assign unused_in = ^{zero, ir_q[31], ir_q[29:15], ir_q[11:7]};

  always_comb begin
    is_r   = (ir_q[6:0] == 7'h33);
    is_i   = (ir_q[6:0] == 7'h13);
    is_lw  = (ir_q[6:0] == 7'h03);
    is_sw  = (ir_q[6:0] == 7'h23);
    is_beq = (ir_q[6:0] == 7'h63);
    is_jal = (ir_q[6:0] == 7'h6F);
    legal  = is_r | is_i | is_lw | is_sw | is_beq | is_jal;

    alu_op = OpAdd;
    if (is_beq) begin
      alu_op = OpSub;
    end else if (is_r) begin
      case (ir_q[14:12])
        3'b110:  alu_op = OpOr;
        3'b111:  alu_op = OpAnd;
        3'b000:  alu_op = ir_q[30] ? OpSub : OpAdd;
        default: alu_op = OpAdd;
      endcase
    end
    alu_src = is_i | is_lw | is_sw;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:   state_d = StFetch;
      StFetch:  state_d = run ? StDecode : StFetch;
      StDecode: state_d = legal ? StExec : StHalt;
      StExec: begin
        if (is_r || is_i)        state_d = StWb;
        else if (is_lw || is_sw) state_d = StMem;
        else                     state_d = StFetch;
      end
      StMem:    state_d = is_lw ? StWb : StFetch;
      StWb:     state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StBoot;
    endcase
  end

  always_comb begin
    INT      = 1'b0;
    pc_we    = 1'b0;
    ir_we    = 1'b0;
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    op       = OpAnd;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Mem2Reg  = 1'b0;
    isBranch = 1'b0;
    isJump   = 1'b0;
    halt     = 1'b0;
    unique case (state_q)
      StBoot: begin
        INT   = 1'b1;
        pc_we = 1'b1;
      end
      StFetch: ir_we = run;
      StExec: begin
        ALUSrc   = alu_src;
        op       = alu_op;
        pc_we    = is_beq | is_jal;
        isBranch = is_beq;
        isJump   = is_jal;
      end
      StMem: begin
        ALUSrc   = alu_src;
        op       = alu_op;
        MemRead  = is_lw;
        MemWrite = is_sw;
        pc_we    = is_sw;
      end
      StWb: begin
        ALUSrc   = alu_src;
        op       = alu_op;
        MemRead  = is_lw;
        Mem2Reg  = is_lw;
        RegWrite = 1'b1;
        pc_we    = 1'b1;
      end
      StHalt:  halt = 1'b1;
      default: ;
    endcase
    // Reset wins combinationally so an aborted instruction never fires a strobe.
    if (!rst_n) begin
      INT      = 1'b0;
      pc_we    = 1'b0;
      ir_we    = 1'b0;
      RegWrite = 1'b0;
      ALUSrc   = 1'b0;
      op       = OpAnd;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      Mem2Reg  = 1'b0;
      isBranch = 1'b0;
      isJump   = 1'b0;
      halt     = 1'b0;
    end
  end

  assign retired = rst_n ? retired_q : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StBoot;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StFetch && run) ir_q <= ins;
      if (pc_we && state_q != StBoot) retired_q <= retired_q + RET_W'(1);
    end
  end

endmodule

// File: tb/tb_ctl_sequencer.sv
// Cycle-accurate scoreboard bench for ctl_sequencer: per-cycle expected strobes are queued as
// each instruction is issued and compared as the sequencer steps through it.
module tb_ctl_sequencer;

  localparam int unsigned RW = 4;

  logic          clk, rst_n, run, zero;
  logic [31:0]   ins;
  logic          INT, pc_we, ir_we, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg;
  logic          isBranch, isJump, halt;
  logic [2:0]    op;
  logic [RW-1:0] retired;

  ctl_sequencer #(.RET_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .ins(ins), .zero(zero),
    .INT(INT), .pc_we(pc_we), .ir_we(ir_we), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
    .op(op), .MemRead(MemRead), .MemWrite(MemWrite), .Mem2Reg(Mem2Reg),
    .isBranch(isBranch), .isJump(isJump), .halt(halt), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic intr, pc_we, ir_we, reg_write, alu_src;
    logic [2:0] op;
    logic mem_read, mem_write, mem2reg, is_branch, is_jump, halt;
    logic [RW-1:0] retired;
  } exp_t;

  typedef struct packed {
    logic rn, run;
    logic [31:0] ins;
    logic zero;
  } stim_t;

  exp_t  exp_q[$];
  stim_t stim_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;
  logic [RW-1:0] exp_ret = '0;

  function automatic exp_t blank();
    exp_t e;
    e = '0;
    e.retired = exp_ret;
    return e;
  endfunction

  function automatic stim_t busy();
    stim_t s;
    s.rn = 1'b1;
    s.run = 1'b1;
    s.ins = $urandom();
    s.zero = 1'(($urandom_range(0, 1)));
    return s;
  endfunction

  task automatic push(input stim_t s, input exp_t e, input string n);
    stim_q.push_back(s);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic push_reset();
    stim_t s;
    exp_t  e;
    s = busy();
    s.rn = 1'b0;
    e = '0;
    push(s, e, "reset_low");
    exp_ret = '0;
    e = blank();
    e.intr = 1'b1;
    e.pc_we = 1'b1;
    push(busy(), e, "boot");
  endtask

  task automatic push_fetch_decode(input logic [31:0] w, input logic z);
    stim_t s;
    exp_t  e;
    s.rn = 1'b1;
    s.run = 1'b1;
    s.ins = w;
    s.zero = z;
    e = blank();
    e.ir_we = 1'b1;
    push(s, e, "fetch");
    push(busy(), blank(), "decode");
  endtask

  task automatic push_insn(input logic [31:0] w, input logic z);
    exp_t e;
    logic [2:0] rop;
    push_fetch_decode(w, z);
    case (w[14:12])
      3'b110:  rop = 3'b001;
      3'b111:  rop = 3'b000;
      3'b000:  rop = w[30] ? 3'b110 : 3'b010;
      default: rop = 3'b010;
    endcase
    case (w[6:0])
      7'h33, 7'h13: begin
        e = blank(); e.alu_src = (w[6:0] == 7'h13);
        e.op = (w[6:0] == 7'h33) ? rop : 3'b010;
        push(busy(), e, "exec_alu");
        e.reg_write = 1'b1; e.pc_we = 1'b1;
        push(busy(), e, "wb_alu");
      end
      7'h03: begin
        e = blank(); e.alu_src = 1'b1; e.op = 3'b010;
        push(busy(), e, "exec_lw");
        e.mem_read = 1'b1;
        push(busy(), e, "mem_lw");
        e.mem2reg = 1'b1; e.reg_write = 1'b1; e.pc_we = 1'b1;
        push(busy(), e, "wb_lw");
      end
      7'h23: begin
        e = blank(); e.alu_src = 1'b1; e.op = 3'b010;
        push(busy(), e, "exec_sw");
        e.mem_write = 1'b1; e.pc_we = 1'b1;
        push(busy(), e, "mem_sw");
      end
      7'h63: begin
        e = blank(); e.op = 3'b110; e.is_branch = 1'b1; e.pc_we = 1'b1;
        push(busy(), e, "exec_beq");
      end
      default: begin
        e = blank(); e.op = 3'b010; e.is_jump = 1'b1; e.pc_we = 1'b1;
        push(busy(), e, "exec_jal");
      end
    endcase
    exp_ret = exp_ret + 1'b1;
  endtask

  task automatic run_queue();
    stim_t s;
    exp_t  e, act;
    string n;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      n = name_q.pop_front();
      rst_n = s.rn; run = s.run; ins = s.ins; zero = s.zero;
      #1;
      act.intr = INT; act.pc_we = pc_we; act.ir_we = ir_we; act.reg_write = RegWrite;
      act.alu_src = ALUSrc; act.op = op; act.mem_read = MemRead; act.mem_write = MemWrite;
      act.mem2reg = Mem2Reg; act.is_branch = isBranch; act.is_jump = isJump;
      act.halt = halt; act.retired = retired;
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s: got %h expected %h", n, act, e);
      end
      @(posedge clk);
      #2;
    end
  endtask

  task automatic test_reset();
    push_reset();
    run_queue();
  endtask

  task automatic test_single();
    push_insn(32'h0050_0093, 1'b0);  // addi
    push_insn(32'h0000_A103, 1'b0);  // lw
    push_insn(32'h0020_A023, 1'b0);  // sw
    push_insn(32'h0020_8463, 1'b1);  // beq, taken
    run_queue();
  endtask

  task automatic test_back_to_back();
    push_insn(32'h0020_81B3, 1'b0);  // add
    push_insn(32'h4020_81B3, 1'b0);  // sub
    push_insn(32'h0020_E1B3, 1'b0);  // or
    push_insn(32'h0020_F1B3, 1'b0);  // and
    push_insn(32'h0020_A1B3, 1'b0);  // slt -> add
    push_insn(32'h4020_F1B3, 1'b0);  // and with bit30 set
    push_insn(32'h0080_006F, 1'b1);  // jal
    push_insn(32'h0020_8463, 1'b0);  // beq, not taken
    push_insn(32'h0050_7093, 1'b0);  // andi -> add
    run_queue();
  endtask

  task automatic test_run_low();
    stim_t s;
    for (int i = 0; i < 5; i++) begin
      s = busy();
      s.run = 1'b0;
      push(s, blank(), "fetch_idle");
    end
    push_insn(32'h0050_0093, 1'b0);
    run_queue();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 18; i++) push_insn(32'h0020_8463, 1'(i & 1));
    run_queue();
  endtask

  task automatic test_reset_mid_sw();
    exp_t e;
    push_fetch_decode(32'h0020_A023, 1'b0);
    e = blank(); e.alu_src = 1'b1; e.op = 3'b010;
    push(busy(), e, "exec_sw_abort");
    push_reset();
    push_insn(32'h0050_0093, 1'b0);
    run_queue();
  endtask

  task automatic test_halt();
    exp_t e;
    push_fetch_decode(32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 10; i++) begin
      e = blank();
      e.halt = 1'b1;
      push(busy(), e, "halt_sticky");
    end
    push_reset();
    push_insn(32'h0000_A103, 1'b0);
    run_queue();
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; ins = '0; zero = 1'b0;
    @(posedge clk);
    #2;
    test_reset();
    test_single();
    test_back_to_back();
    test_run_low();
    test_wrap();
    test_reset_mid_sw();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
